// File: rtl/isa_resp_pkg.sv
// Shared types and constants for the ISA I/O responder.
// State encodings, port-offset width and default float value.
package isa_resp_pkg;

    localparam int unsigned OFFS_W = 4;

    localparam logic [7:0] FLOAT_DATA_DEF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_HOLD  = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_DRIVE = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

endpackage

// File: rtl/isa_strobe_sync.sv
// Two-flop synchronizer for an active-low ISA strobe.
// A third flop provides the previous value for edge detection.
module isa_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n_i,
    output logic sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle level of the strobe is high, so reset to 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= strobe_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;
    assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/isa_io_responder.sv
// ISA I/O target: decodes a 16-port window and bridges
// IOW/IOR cycles to a local register interface.
module isa_io_responder
    import isa_resp_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR    = 10'h220,
    parameter int unsigned READ_TIMEOUT = 15,
    parameter logic [7:0]  FLOAT_DATA   = FLOAT_DATA_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        isa_addr,
    input  logic              isa_aen,
    input  logic              isa_iow_n,
    input  logic              isa_ior_n,
    input  logic [7:0]        isa_data_in,
    output logic [7:0]        isa_data_out,
    output logic              isa_data_oe,
    output logic              iochrdy_low,
    output logic              loc_wr_valid,
    output logic [OFFS_W-1:0] loc_wr_addr,
    output logic [7:0]        loc_wr_data,
    output logic              loc_rd_req,
    output logic [OFFS_W-1:0] loc_rd_addr,
    input  logic              loc_rd_valid,
    input  logic [7:0]        loc_rd_data,
    output logic              timeout_err
);

    localparam logic [3:0] TMO = 4'(READ_TIMEOUT);

    logic iow_sync, iow_fall, iow_rise;
    logic ior_sync, ior_fall, ior_rise;

    isa_strobe_sync u_iow_sync (
        .clk        (clk),
        .reset      (reset),
        .strobe_n_i (isa_iow_n),
        .sync_o     (iow_sync),
        .fall_o     (iow_fall),
        .rise_o     (iow_rise)
    );

    isa_strobe_sync u_ior_sync (
        .clk        (clk),
        .reset      (reset),
        .strobe_n_i (isa_ior_n),
        .sync_o     (ior_sync),
        .fall_o     (ior_fall),
        .rise_o     (ior_rise)
    );

    state_e state_q, state_d;

    logic              wr_valid_q, wr_valid_d;
    logic [OFFS_W-1:0] wr_addr_q,  wr_addr_d;
    logic [7:0]        wr_data_q,  wr_data_d;
    logic              rd_req_q,   rd_req_d;
    logic [OFFS_W-1:0] rd_addr_q,  rd_addr_d;
    logic              iochrdy_q,  iochrdy_d;
    logic [7:0]        dout_q,     dout_d;
    logic              drive_q,    drive_d;
    logic [3:0]        timer_q,    timer_d;
    logic              tmo_q,      tmo_d;

    logic hit, both_fall, wr_go, rd_go, tmo_hit;

    assign hit       = ~isa_aen & (isa_addr[9:4] == BASE_ADDR[9:4]);
    assign both_fall = iow_fall & ior_fall;
    assign wr_go     = iow_fall & hit & ~ior_fall;
    assign rd_go     = ior_fall & hit & ~iow_fall;
    assign tmo_hit   = (timer_q + 4'd1) == TMO;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            iochrdy_q  <= 1'b0;
            dout_q     <= '0;
            drive_q    <= 1'b0;
            timer_q    <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            iochrdy_q  <= iochrdy_d;
            dout_q     <= dout_d;
            drive_q    <= drive_d;
            timer_q    <= timer_d;
            tmo_q      <= tmo_d;
        end
    end

    // RD_DRIVE may be entered in the same cycle as the IOR rise,
    // so it leaves on the synchronized level rather than the edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (both_fall)  state_d = ST_RELEASE;
                else if (wr_go) state_d = ST_WR_HOLD;
                else if (rd_go) state_d = ST_RD_WAIT;
            end
            ST_WR_HOLD: begin
                if (iow_rise) state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (loc_rd_valid | tmo_hit) state_d = ST_RD_DRIVE;
                else if (ior_rise)          state_d = ST_IDLE;
            end
            ST_RD_DRIVE: begin
                if (ior_sync) state_d = ST_IDLE;
            end
            ST_RELEASE: begin
                if (iow_sync & ior_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        iochrdy_d  = iochrdy_q;
        dout_d     = dout_q;
        drive_d    = drive_q;
        timer_d    = timer_q;
        tmo_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_go) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = isa_addr[OFFS_W-1:0];
                    wr_data_d  = isa_data_in;
                end else if (rd_go) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = isa_addr[OFFS_W-1:0];
                    iochrdy_d = 1'b1;
                    timer_d   = '0;
                end
            end
            ST_RD_WAIT: begin
                timer_d = timer_q + 4'd1;
                if (loc_rd_valid) begin
                    dout_d    = loc_rd_data;
                    drive_d   = 1'b1;
                    iochrdy_d = 1'b0;
                end else if (tmo_hit) begin
                    dout_d    = FLOAT_DATA;
                    drive_d   = 1'b1;
                    iochrdy_d = 1'b0;
                    tmo_d     = 1'b1;
                end else if (ior_rise) begin
                    iochrdy_d = 1'b0;
                end
            end
            ST_RD_DRIVE: begin
                if (ior_sync) drive_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign isa_data_out = dout_q;
    assign isa_data_oe  = drive_q & ~isa_ior_n;
    assign iochrdy_low  = iochrdy_q;
    assign loc_wr_valid = wr_valid_q;
    assign loc_wr_addr  = wr_addr_q;
    assign loc_wr_data  = wr_data_q;
    assign loc_rd_req   = rd_req_q;
    assign loc_rd_addr  = rd_addr_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_isa_io_responder.sv
// Directed bench for isa_io_responder: writes, reads,
// timeout, decode misses, strobe collisions and aborts.
module tb_isa_io_responder;

    logic       clk;
    logic       reset;
    logic [9:0] isa_addr;
    logic       isa_aen;
    logic       isa_iow_n;
    logic       isa_ior_n;
    logic [7:0] isa_data_in;
    logic [7:0] isa_data_out;
    logic       isa_data_oe;
    logic       iochrdy_low;
    logic       loc_wr_valid;
    logic [3:0] loc_wr_addr;
    logic [7:0] loc_wr_data;
    logic       loc_rd_req;
    logic [3:0] loc_rd_addr;
    logic       loc_rd_valid;
    logic [7:0] loc_rd_data;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    isa_io_responder dut (
        .clk          (clk),
        .reset        (reset),
        .isa_addr     (isa_addr),
        .isa_aen      (isa_aen),
        .isa_iow_n    (isa_iow_n),
        .isa_ior_n    (isa_ior_n),
        .isa_data_in  (isa_data_in),
        .isa_data_out (isa_data_out),
        .isa_data_oe  (isa_data_oe),
        .iochrdy_low  (iochrdy_low),
        .loc_wr_valid (loc_wr_valid),
        .loc_wr_addr  (loc_wr_addr),
        .loc_wr_data  (loc_wr_data),
        .loc_rd_req   (loc_rd_req),
        .loc_rd_addr  (loc_rd_addr),
        .loc_rd_valid (loc_rd_valid),
        .loc_rd_data  (loc_rd_data),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for loc_rd_req; lat = negedges after strobe drive.
    task automatic wait_req(output int lat);
        int n;
        lat = -1;
        n = 0;
        while (lat < 0 && n < 8) begin
            @(negedge clk);
            if (loc_rd_req) lat = n;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (isa_data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_dout: got %h expected 00", isa_data_out);
        end
        n_checks++;
        if (isa_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_oe: got %b expected 0", isa_data_oe);
        end
        n_checks++;
        if (iochrdy_low !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rdy: got %b expected 0", iochrdy_low);
        end
        n_checks++;
        if ({loc_wr_valid, loc_rd_req, timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_pulses: got %b expected 000",
                     {loc_wr_valid, loc_rd_req, timeout_err});
        end
        n_checks++;
        if ({loc_wr_addr, loc_wr_data, loc_rd_addr} !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_addr: got %h expected 0000",
                     {loc_wr_addr, loc_wr_data, loc_rd_addr});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_hit;
        int p, idx;
        logic [3:0] a;
        logic [7:0] d;
        p = 0; idx = -1; a = '0; d = '0;
        isa_addr    = 10'h22C;
        isa_data_in = 8'h5A;
        isa_iow_n   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (loc_wr_valid) begin
                p++;
                if (idx < 0) begin
                    idx = i; a = loc_wr_addr; d = loc_wr_data;
                end
            end
            if (i == 4) isa_iow_n = 1'b1;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (p != 1) begin
            n_fail++;
            $display("FAIL wr_pulses: got %0d expected 1", p);
        end
        n_checks++;
        if (idx != 2) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d expected 2", idx);
        end
        n_checks++;
        if (a !== 4'hC) begin
            n_fail++;
            $display("FAIL wr_addr: got %h expected c", a);
        end
        n_checks++;
        if (d !== 8'h5A) begin
            n_fail++;
            $display("FAIL wr_data: got %h expected 5a", d);
        end
    endtask

    // Local side answers in the third cycle after the request cycle,
    // so IOCHRDY is held for the request cycle plus three more.
    task automatic test_read_resp;
        int lat, hi, extra, bad;
        isa_addr  = 10'h221;
        isa_ior_n = 1'b0;
        wait_req(lat);
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL rd_latency: got %0d expected 2", lat);
        end
        n_checks++;
        if (loc_rd_addr !== 4'h1) begin
            n_fail++;
            $display("FAIL rd_addr: got %h expected 1", loc_rd_addr);
        end
        hi = iochrdy_low ? 1 : 0;
        extra = 0; bad = 0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (loc_rd_req) extra++;
            if (iochrdy_low) hi++;
            if (j <= 3 && loc_rd_addr !== 4'h1) bad++;
            if (timeout_err) bad++;
            loc_rd_valid = (j == 3);
            loc_rd_data  = (j == 3) ? 8'hA5 : 8'h00;
        end
        n_checks++;
        if (hi != 4) begin
            n_fail++;
            $display("FAIL rd_wait_cycles: got %0d expected 4", hi);
        end
        n_checks++;
        if (extra != 0 || bad != 0) begin
            n_fail++;
            $display("FAIL rd_req_hold: got %0d/%0d expected 0/0",
                     extra, bad);
        end
        n_checks++;
        if (isa_data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_data: got %h expected a5", isa_data_out);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (isa_data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_oe_on: got %b expected 1", isa_data_oe);
        end
        isa_ior_n = 1'b1;
        #1;
        n_checks++;
        if (isa_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_oe_off: got %b expected 0", isa_data_oe);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read_timeout;
        int lat, hi, tm, tidx;
        logic [7:0] d;
        logic oe;
        d = '0; oe = 1'b0; tidx = -1; tm = 0;
        isa_addr  = 10'h22F;
        isa_ior_n = 1'b0;
        wait_req(lat);
        hi = iochrdy_low ? 1 : 0;
        for (int j = 1; j < 24; j++) begin
            @(negedge clk);
            if (iochrdy_low) hi++;
            if (timeout_err) begin
                tm++;
                if (tidx < 0) begin
                    tidx = j; d = isa_data_out; oe = isa_data_oe;
                end
            end
        end
        n_checks++;
        if (hi != 15) begin
            n_fail++;
            $display("FAIL tmo_wait_cycles: got %0d expected 15", hi);
        end
        n_checks++;
        if (tm != 1 || tidx != 15) begin
            n_fail++;
            $display("FAIL tmo_pulse: got %0d@%0d expected 1@15",
                     tm, tidx);
        end
        n_checks++;
        if (d !== 8'hFF || oe !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_data: got %h/%b expected ff/1", d, oe);
        end
        isa_ior_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_miss_dma;
        int wr, rd, rdy;
        wr = 0; rd = 0; rdy = 0;
        for (int k = 0; k < 3; k++) begin
            isa_addr = (k == 0) ? 10'h330 : 10'h220;
            isa_aen  = (k != 0);
            isa_data_in = 8'h99;
            if (k == 2) isa_ior_n = 1'b0;
            else        isa_iow_n = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (loc_wr_valid) wr++;
                if (loc_rd_req) rd++;
                if (iochrdy_low) rdy++;
                if (i == 5) begin
                    isa_iow_n = 1'b1; isa_ior_n = 1'b1;
                end
            end
        end
        isa_aen = 1'b0;
        n_checks++;
        if (wr != 0) begin
            n_fail++;
            $display("FAIL miss_wr: got %0d expected 0", wr);
        end
        n_checks++;
        if (rd != 0) begin
            n_fail++;
            $display("FAIL miss_rd: got %0d expected 0", rd);
        end
        n_checks++;
        if (rdy != 0) begin
            n_fail++;
            $display("FAIL miss_rdy: got %0d expected 0", rdy);
        end
    endtask

    task automatic test_simultaneous;
        int bad, p, idx;
        logic [3:0] a;
        logic [7:0] d;
        bad = 0; p = 0; idx = -1; a = '0; d = '0;
        isa_addr    = 10'h223;
        isa_data_in = 8'h11;
        isa_iow_n   = 1'b0;
        isa_ior_n   = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (loc_wr_valid || loc_rd_req || iochrdy_low) bad++;
            if (i == 5) isa_iow_n = 1'b1;
            if (i == 8) isa_ior_n = 1'b1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sim_pulses: got %0d expected 0", bad);
        end
        isa_addr    = 10'h227;
        isa_data_in = 8'h3C;
        isa_iow_n   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (loc_wr_valid) begin
                p++;
                if (idx < 0) begin
                    idx = i; a = loc_wr_addr; d = loc_wr_data;
                end
            end
            if (i == 3) isa_iow_n = 1'b1;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (p != 1 || idx != 2) begin
            n_fail++;
            $display("FAIL sim_next_wr: got %0d@%0d expected 1@2",
                     p, idx);
        end
        n_checks++;
        if (a !== 4'h7 || d !== 8'h3C) begin
            n_fail++;
            $display("FAIL sim_next_data: got %h/%h expected 7/3c",
                     a, d);
        end
    endtask

    task automatic test_reset_mid_read;
        int lat;
        isa_addr  = 10'h224;
        isa_ior_n = 1'b0;
        wait_req(lat);
        repeat (2) @(negedge clk);
        n_checks++;
        if (iochrdy_low !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: got %b expected 1", iochrdy_low);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (iochrdy_low !== 1'b0 || isa_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_rdy_oe: got %b%b expected 00",
                     iochrdy_low, isa_data_oe);
        end
        n_checks++;
        if ({loc_wr_valid, loc_rd_req, timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_pulses: got %b expected 000",
                     {loc_wr_valid, loc_rd_req, timeout_err});
        end
        n_checks++;
        if (isa_data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rmid_dout: got %h expected 00", isa_data_out);
        end
        isa_ior_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort;
        int lat, lo, tm;
        lo = -1; tm = 0;
        isa_addr  = 10'h225;
        isa_ior_n = 1'b0;
        wait_req(lat);
        n_checks++;
        if (lat != 2 || isa_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL abt_start: got %0d/%b expected 2/0",
                     lat, isa_data_oe);
        end
        @(negedge clk);
        isa_ior_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!iochrdy_low && lo < 0) lo = k;
            if (timeout_err) tm++;
        end
        n_checks++;
        if (lo != 2 || tm != 0) begin
            n_fail++;
            $display("FAIL abt_release: got %0d/%0d expected 2/0",
                     lo, tm);
        end
        n_checks++;
        if (isa_data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL abt_dout: got %h expected 00", isa_data_out);
        end
        isa_addr  = 10'h226;
        isa_ior_n = 1'b0;
        wait_req(lat);
        n_checks++;
        if (lat != 2 || isa_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL abt_next_rd: got %0d/%b expected 2/0",
                     lat, isa_data_oe);
        end
        loc_rd_valid = 1'b1;
        loc_rd_data  = 8'h77;
        @(negedge clk);
        loc_rd_valid = 1'b0;
        n_checks++;
        if (isa_data_out !== 8'h77 || isa_data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL abt_next_data: got %h/%b expected 77/1",
                     isa_data_out, isa_data_oe);
        end
        isa_ior_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        isa_addr     = '0;
        isa_aen      = 1'b0;
        isa_iow_n    = 1'b1;
        isa_ior_n    = 1'b1;
        isa_data_in  = '0;
        loc_rd_valid = 1'b0;
        loc_rd_data  = '0;
        test_reset();
        test_write_hit();
        test_read_resp();
        test_read_timeout();
        test_miss_dma();
        test_simultaneous();
        test_reset_mid_read();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
